pc_watch_dump: RTL and testbench

PC_WATCH_DUMP -- requirements
Module: pc_watch_dump

---
 rtl/pc_watch_dump_if.sv | 28 ++
 rtl/pc_watch_dump.sv | 134 +++++++++++++
 tb/tb_pc_watch_dump.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_watch_dump_if.sv
// Memory read port and dump stream bundle for pc_watch_dump.
// The master side is the watcher and the slave side is memory plus the dump sink.
interface pc_watch_dump_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic              dump_eol;

    modport master (
        output mem_rd, mem_addr,
        input  mem_rdata,
        output dump_valid, dump_data, dump_eol,
        input  dump_ready
    );

    modport slave (
        input  mem_rd, mem_addr,
        output mem_rdata,
        input  dump_valid, dump_data, dump_eol,
        output dump_ready
    );
endinterface

// File: rtl/pc_watch_dump.sv
// Watches the PC for end addresses or a cycle limit, then streams a memory window.
// The window is streamed one word at a time over a valid/ready channel.
module pc_watch_dump #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_WATCH      = 2,
    parameter int DUMP_BASE      = 12,
    parameter int DUMP_LEN       = 96,
    parameter int WORDS_PER_LINE = 16,
    parameter int TIMEOUT        = 0,
    localparam int HW = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        arm,
    input  logic [ADDR_W-1:0]           pc,
    input  logic [NUM_WATCH*ADDR_W-1:0] watch_addr,
    input  logic [NUM_WATCH-1:0]        watch_en,
    pc_watch_dump_if.master             bus,
    output logic                        halt,
    output logic                        hit,
    output logic [HW-1:0]               hit_idx,
    output logic                        timeout,
    output logic [31:0]                 cycle_cnt,
    output logic [31:0]                 pc_chg_cnt
);
    typedef enum logic [2:0] {
        IDLE, RUN, READ, WAIT, SEND, DONE
    } state_t;

    localparam logic [31:0] BASE32  = 32'(DUMP_BASE);
    localparam logic [31:0] LAST32  = 32'(DUMP_LEN - 1);
    localparam logic [31:0] WPL32   = 32'(WORDS_PER_LINE);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc_prev;
    logic [31:0]         idx;
    logic [DATA_W-1:0]   data_q;
    logic                match;
    logic [HW-1:0]       midx;
    logic                to_hit;
    logic                last;
    logic                eol;
    logic                rd;
    logic                vld;
    logic                start;

    // Scan from the top slot down so the lowest enabled match wins.
    always_comb begin
        match = 1'b0;
        midx  = '0;
        for (int k = NUM_WATCH - 1; k >= 0; k--) begin
            if (watch_en[k] && pc == watch_addr[k*ADDR_W +: ADDR_W]) begin
                match = 1'b1;
                midx  = HW'(k);
            end
        end
    end

    assign to_hit = (TIMEOUT != 0) && (cycle_cnt == TO_LAST) && !match;
    assign last   = (idx == LAST32);
    assign eol    = ((idx + 32'd1) % WPL32 == 32'd0) || last;
    assign start  = arm && (state == IDLE || state == DONE);

    always_comb begin
        state_n = state;
        rd      = 1'b0;
        vld     = 1'b0;
        unique case (state)
            IDLE: if (arm) state_n = RUN;
            RUN:  if (match || to_hit) state_n = READ;
            READ: begin
                rd      = 1'b1;
                state_n = WAIT;
            end
            WAIT: state_n = SEND;
            SEND: begin
                vld = 1'b1;
                if (bus.dump_ready) state_n = last ? DONE : READ;
            end
            DONE: if (arm) state_n = RUN;
            default: state_n = IDLE;
        endcase
    end

    assign bus.mem_rd     = rd;
    assign bus.mem_addr   = rd ? ADDR_W'(BASE32 + idx) : '0;
    assign bus.dump_valid = vld;
    assign bus.dump_data  = data_q;
    assign bus.dump_eol   = vld & eol;
    assign halt           = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_prev    <= '0;
            idx        <= '0;
            data_q     <= '0;
            hit        <= 1'b0;
            hit_idx    <= '0;
            timeout    <= 1'b0;
            cycle_cnt  <= '0;
            pc_chg_cnt <= '0;
        end else begin
            pc_prev <= pc;
            if (start) begin
                idx        <= '0;
                hit        <= 1'b0;
                hit_idx    <= '0;
                timeout    <= 1'b0;
                cycle_cnt  <= '0;
                pc_chg_cnt <= '0;
            end
            if (state == RUN) begin
                if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
                if (pc != pc_prev && pc_chg_cnt != '1)
                    pc_chg_cnt <= pc_chg_cnt + 32'd1;
                if (match) begin
                    hit     <= 1'b1;
                    hit_idx <= midx;
                end else if (to_hit) begin
                    timeout <= 1'b1;
                end
            end
            if (state == WAIT) data_q <= bus.mem_rdata;
            if (state == SEND && bus.dump_ready && !last) idx <= idx + 32'd1;
        end
    end
endmodule

// File: tb/tb_pc_watch_dump.sv
// Bench for pc_watch_dump: run-end vectors, dump scoreboard, stall, arm and reset cases.
module tb_pc_watch_dump;
    localparam int LEN = 96;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        arm = 1'b0;
    logic [31:0] pc = '0;
    logic [63:0] watch_addr = '0;
    logic [1:0]  watch_en = '0;
    logic        halt, hit, timeout;
    logic [0:0]  hit_idx;
    logic [31:0] cycle_cnt, pc_chg_cnt;

    int total = 0;
    int passed = 0;

    pc_watch_dump_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    pc_watch_dump #(
        .ADDR_W(32), .DATA_W(32), .NUM_WATCH(2), .DUMP_BASE(12),
        .DUMP_LEN(LEN), .WORDS_PER_LINE(16), .TIMEOUT(50)
    ) dut (
        .clk(clk), .reset(reset), .arm(arm), .pc(pc),
        .watch_addr(watch_addr), .watch_en(watch_en), .bus(bus),
        .halt(halt), .hit(hit), .hit_idx(hit_idx), .timeout(timeout),
        .cycle_cnt(cycle_cnt), .pc_chg_cnt(pc_chg_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'hA5A5_0000;
    endfunction

    // Read data appears exactly one cycle after the strobe; garbage otherwise.
    always @(posedge clk)
        bus.mem_rdata <= bus.mem_rd ? memf(bus.mem_addr) : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] pc0, step, w0, w1;
        logic [1:0]  en;
        logic        hit;
        logic [0:0]  idx;
        logic        to;
        logic [31:0] cyc, chg;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    vec_t vt[7];
    exp_t sb[$];

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int stall_word, input int arm_word,
                         input int abort_word, output bit aborted);
        int words = 0;
        int budget = 0;
        int stall = 0;
        int rds = 0;
        bit armed = 0;
        logic [31:0] hd;
        logic he;
        exp_t e;
        aborted = 0;
        bus.dump_ready = 1'b1;
        while (words < LEN && budget < 2000) begin
            arm = 1'b0;
            if (bus.mem_rd) begin
                rds++;
                chk("mem_addr", bus.mem_addr, 32'(12 + words));
            end
            if (bus.dump_valid) begin
                if (words == abort_word) begin
                    reset = 1'b0;
                    #1;
                    chk("rst_strobes", {bus.dump_valid, bus.dump_eol, bus.mem_rd}, 0);
                    chk("rst_data", bus.dump_data, 0);
                    chk("rst_addr", bus.mem_addr, 0);
                    chk("rst_flags", {halt, hit, hit_idx, timeout}, 0);
                    chk("rst_cyc", cycle_cnt, 0);
                    chk("rst_chg", pc_chg_cnt, 0);
                    sb.delete();
                    aborted = 1;
                    return;
                end
                if (words == arm_word && !armed) begin
                    arm = 1'b1;
                    armed = 1;
                end
                if (words == stall_word && stall < 10) begin
                    if (stall == 0) begin
                        hd = bus.dump_data;
                        he = bus.dump_eol;
                    end else begin
                        chk("stall_data", bus.dump_data, hd);
                        chk("stall_eol", bus.dump_eol, he);
                        chk("stall_rd", bus.mem_rd, 0);
                    end
                    bus.dump_ready = 1'b0;
                    stall++;
                end else begin
                    bus.dump_ready = 1'b1;
                    e = sb.pop_front();
                    chk("dump_data", bus.dump_data, e.d);
                    chk("dump_eol", bus.dump_eol, e.e);
                    words++;
                end
            end
            tick();
            budget++;
        end
        arm = 1'b0;
        chk("dump_budget", budget < 2000, 1);
        chk("halt_done", halt, 1);
        chk("rd_count", rds, LEN);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic run_vec(input vec_t v, input bit from_done, input int stall_word,
                           input int arm_word, input int abort_word, output bit aborted);
        int n = 0;
        int b = 0;
        pc = v.pc0;
        watch_addr = {v.w1, v.w0};
        watch_en = v.en;
        bus.dump_ready = 1'b1;
        tick();
        if (from_done) chk("halt_before_arm", halt, 1);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_halt", halt, 0);
        chk("arm_clear", {hit, timeout, cycle_cnt, pc_chg_cnt}, 0);
        for (int i = 0; i < LEN; i++)
            sb.push_back('{d: memf(32'(12 + i)),
                           e: ((i + 1) % 16 == 0) || (i == LEN - 1)});
        while (b < 200) begin
            tick();
            b++;
            if (bus.mem_rd) break;
            n++;
            pc = v.pc0 + v.step * 32'(n);
        end
        chk("run_budget", b < 200, 1);
        chk("hit", hit, v.hit);
        chk("hit_idx", hit_idx, v.idx);
        chk("timeout", timeout, v.to);
        chk("cycle_cnt", cycle_cnt, v.cyc);
        chk("pc_chg_cnt", pc_chg_cnt, v.chg);
        drain(stall_word, arm_word, abort_word, aborted);
        if (!aborted) begin
            chk("cycle_frozen", cycle_cnt, v.cyc);
            chk("chg_frozen", pc_chg_cnt, v.chg);
            chk("hit_kept", {hit, hit_idx, timeout}, {v.hit, v.idx, v.to});
        end
    endtask

    initial begin
        bit ab;
        vt[0] = '{32'h0, 32'h4, 32'h30, 32'h20, 2'b11, 1'b1, 1'b1, 1'b0, 32'd9, 32'd8};
        vt[1] = '{32'h0, 32'h4, 32'h30, 32'h30, 2'b11, 1'b1, 1'b0, 1'b0, 32'd13, 32'd12};
        vt[2] = '{32'h0, 32'h4, 32'h30, 32'h30, 2'b10, 1'b1, 1'b1, 1'b0, 32'd13, 32'd12};
        vt[3] = '{32'h0, 32'h4, 32'h30, 32'h30, 2'b00, 1'b0, 1'b0, 1'b1, 32'd50, 32'd49};
        vt[4] = '{32'h8, 32'h0, 32'h30, 32'h20, 2'b11, 1'b0, 1'b0, 1'b1, 32'd50, 32'd0};
        vt[5] = '{32'h0, 32'h1, 32'h31, 32'h100, 2'b01, 1'b1, 1'b0, 1'b0, 32'd50, 32'd49};
        vt[6] = '{32'h0, 32'h0, 32'h100, 32'h0, 2'b11, 1'b1, 1'b1, 1'b0, 32'd1, 32'd0};

        bus.dump_ready = 1'b1;
        tick();
        tick();
        chk("reset_strobes", {bus.mem_rd, bus.dump_valid, bus.dump_eol}, 0);
        chk("reset_addr", bus.mem_addr, 0);
        chk("reset_flags", {halt, hit, hit_idx, timeout}, 0);
        chk("reset_cnts", {cycle_cnt, pc_chg_cnt}, 0);
        reset = 1'b1;

        run_vec(vt[0], 0, 5, 3, -1, ab);
        for (int i = 1; i < 7; i++) run_vec(vt[i], 1, -1, -1, -1, ab);

        run_vec(vt[0], 1, -1, -1, 40, ab);
        chk("abort_seen", ab, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold", {halt, hit, bus.dump_valid, bus.mem_rd, cycle_cnt}, 0);
        end
        reset = 1'b1;
        run_vec(vt[0], 0, -1, -1, -1, ab);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
